fm_audio_decimator: RTL and testbench

- Final audio stage between the FM demodulator and the WM8731 controller.
- Takes demodulated signed audio samples at DECIM × 32 kHz and boxcar-averages each group of DECIM samples down to 32 kHz.
- Applies first-order IIR de-emphasis to each decimated sample.
- Presents a held, saturated 16-bit sample on audio_dat for the serializer.
- Runs on the single 240 MHz clock domain using clock enables.

---
 rtl/fm_audio_decimator.sv | 147 ++++++++++++++
 tb/tb_fm_audio_decimator.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_audio_decimator.sv
// fm_audio_decimator: boxcar decimation of demodulated audio by DECIM, optional
// first-order de-emphasis IIR, and a held, saturated 16-bit output sample.
// The IIR is built only when FM_AUDIO_DEEMPH_EN is defined; without it the
// decimated sample goes straight to the output, with the same 2-clk latency.
// Pipeline: en32k edge -> x (stage 1) -> y or mid (stage 2) -> audio_dat (stage 3).
module fm_audio_decimator #(
  parameter int DECIM        = 8,
  parameter int LOG2_DECIM   = 3,
  parameter int DEEMPH_SHIFT = 1,
  parameter int FRAC         = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_in,
  input  logic [15:0] in_dat,
  input  logic        en32k,
  output logic [15:0] audio_dat,
  output logic        out_valid,
  output logic        rate_err
);

  localparam int ACC_W = 16 + LOG2_DECIM;
  localparam int CNT_W = LOG2_DECIM + 1;
  localparam int Y_W   = 16 + FRAC + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] DECIM_C = CNT_W'(DECIM);

  // Parameter consistency is checked at elaboration time.
  generate
    if (DECIM != (1 << LOG2_DECIM) || DECIM < 2 || DECIM > 64) begin : g_bad_decim
      $error("fm_audio_decimator: DECIM must be 2**LOG2_DECIM within 2..64");
    end
    if (DEEMPH_SHIFT < 1 || DEEMPH_SHIFT >= Y_W || FRAC < 1) begin : g_bad_iir
      $error("fm_audio_decimator: DEEMPH_SHIFT/FRAC out of range");
    end
  endgenerate

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [15:0]      x_q, x_d;
  logic                    rate_err_q, rate_err_d;
  logic        [2:0]       vld_pipe_q, vld_pipe_d;
  logic        [15:0]      audio_q, audio_d;
  logic signed [ACC_W-1:0] in_ext;

  assign in_ext = {{LOG2_DECIM{in_dat[15]}}, in_dat};

  // Window accumulation; a sample coincident with en32k opens the new window.
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    rate_err_d = rate_err_q;
    if (en32k) begin
      // Dropping the low bits is an arithmetic shift (floor toward -inf).
      x_d        = acc_q[ACC_W-1:LOG2_DECIM];
      rate_err_d = rate_err_q | (cnt_q != DECIM_C);
      acc_d      = en_in ? in_ext : '0;
      cnt_d      = en_in ? CNT_W'(1) : '0;
    end else if (en_in) begin
      acc_d = acc_q + in_ext;
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  // Valid bits: [0] x loaded, [1] stage 2 loaded, [2] output pulse.
  always_comb begin
    vld_pipe_d = {vld_pipe_q[1:0], en32k};
  end

`ifdef FM_AUDIO_DEEMPH_EN
  logic signed [Y_W-1:0] y_q, y_d;
  logic signed [Y_W:0]   x_ext, y_ext, diff, step;
  logic        [16:0]    y_int;

  // De-emphasis: y += ((x << FRAC) - y) >>> DEEMPH_SHIFT, one bit wider so the
  // difference never overflows; y stays between its old value and the target.
  always_comb begin
    x_ext = {{2{x_q[15]}}, x_q, {FRAC{1'b0}}};
    y_ext = {y_q[Y_W-1], y_q};
    diff  = x_ext - y_ext;
    step  = diff >>> DEEMPH_SHIFT;
    y_d   = y_q;
    if (vld_pipe_q[0]) y_d = Y_W'(y_ext + step);
  end

  // Output stage: integer part of y, clamped to the 16-bit signed range.
  always_comb begin
    y_int   = y_q[Y_W-1:FRAC];
    audio_d = audio_q;
    if (vld_pipe_q[1]) begin
      if (y_int[16] != y_int[15]) audio_d = y_int[16] ? 16'h8000 : 16'h7fff;
      else                        audio_d = y_int[15:0];
    end
  end

  // IIR state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) y_q <= '0;
    else       y_q <= y_d;
  end
`else
  logic [15:0] mid_q, mid_d;

  // Stage 2 is a plain delay so the output latency matches the IIR build.
  always_comb begin
    mid_d = mid_q;
    if (vld_pipe_q[0]) mid_d = x_q;
  end

  // Output stage: x already spans exactly the 16-bit range, so the clamp is a pass-through.
  always_comb begin
    audio_d = audio_q;
    if (vld_pipe_q[1]) audio_d = mid_q;
  end

  // Stage-2 delay register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mid_q <= '0;
    else       mid_q <= mid_d;
  end
`endif

  // Shared state registers; reset also cancels any in-flight output pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      x_q        <= '0;
      rate_err_q <= 1'b0;
      vld_pipe_q <= '0;
      audio_q    <= '0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      rate_err_q <= rate_err_d;
      vld_pipe_q <= vld_pipe_d;
      audio_q    <= audio_d;
    end
  end

  assign audio_dat = audio_q;
  assign out_valid = vld_pipe_q[2];
  assign rate_err  = rate_err_q;

endmodule

// File: tb/tb_fm_audio_decimator.sv
// Bench for fm_audio_decimator: window-level reference model (sum, floor-divide,
// IIR in plain integer arithmetic) checked against the DUT for directed and random windows.
module tb_fm_audio_decimator;
  localparam int DECIM = 8;
  localparam int LOG2  = 3;
  localparam int SHIFT = 1;
  localparam int FRAC  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en_in = 1'b0;
  logic        en32k = 1'b0;
  logic [15:0] in_dat = '0;
  logic [15:0] audio_dat;
  logic        out_valid;
  logic        rate_err;

  always #2 clk = ~clk;

  fm_audio_decimator #(
    .DECIM(DECIM), .LOG2_DECIM(LOG2), .DEEMPH_SHIFT(SHIFT), .FRAC(FRAC)
  ) dut (
    .clk(clk), .reset(reset), .en_in(en_in), .in_dat(in_dat), .en32k(en32k),
    .audio_dat(audio_dat), .out_valid(out_valid), .rate_err(rate_err)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  longint m_sum;
  int     m_cnt;
  longint m_y;
  bit     m_err;
  int     exp_dat;

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  function automatic int sat16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  task automatic model_reset();
    m_sum = 0; m_cnt = 0; m_y = 0; m_err = 1'b0; exp_dat = 0;
  endtask

  task automatic feed(input int v);
    en_in = 1'b1; in_dat = 16'(v);
    @(posedge clk); #1;
    en_in = 1'b0;
    m_sum += v; m_cnt++;
  endtask

  // Closes a window, advances the model, and captures out_valid over 4 cycles.
  task automatic close_win(input bit coinc, input int cval, output int got, output logic [3:0] vpat);
    longint x;
    en32k = 1'b1;
    if (coinc) begin en_in = 1'b1; in_dat = 16'(cval); end
    @(posedge clk); #1;
    en32k = 1'b0; en_in = 1'b0;
    x = fdiv(m_sum, DECIM);
    if (m_cnt != DECIM) m_err = 1'b1;
    if (coinc) begin m_sum = cval; m_cnt = 1; end
    else       begin m_sum = 0;    m_cnt = 0; end
`ifdef FM_AUDIO_DEEMPH_EN
    m_y = m_y + fdiv(x * (1 << FRAC) - m_y, 1 << SHIFT);
    exp_dat = sat16(fdiv(m_y, 1 << FRAC));
`else
    exp_dat = sat16(x);
`endif
    @(negedge clk); vpat[0] = out_valid;
    @(negedge clk); vpat[1] = out_valid;
    @(negedge clk); vpat[2] = out_valid; got = int'($signed(audio_dat));
    @(negedge clk); vpat[3] = out_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (audio_dat !== 16'd0) begin bad++; $display("FAIL reset_dat got=%0d exp=0", audio_dat); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", out_valid); end
    total++; if (rate_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", rate_err); end
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_dc();
    int got; logic [3:0] vp;
`ifdef FM_AUDIO_DEEMPH_EN
    int first[4] = '{500, 750, 875, 937};
`else
    int first[4] = '{1000, 1000, 1000, 1000};
`endif
    for (int w = 0; w < 20; w++) begin
      for (int i = 0; i < DECIM; i++) feed(1000);
      close_win(1'b0, 0, got, vp);
      total++; if (got !== exp_dat) begin bad++; $display("FAIL dc_dat w=%0d got=%0d exp=%0d", w, got, exp_dat); end
      total++; if (vp !== 4'b0100) begin bad++; $display("FAIL dc_vld w=%0d got=%b exp=0100", w, vp); end
      if (w < 4) begin
        total++; if (got !== first[w]) begin bad++; $display("FAIL dc_seq w=%0d got=%0d exp=%0d", w, got, first[w]); end
      end
      if (w == 19) begin
        total++; if (got != 1000 && got != 999) begin bad++; $display("FAIL dc_final got=%0d exp=999..1000", got); end
      end
    end
    total++; if (rate_err !== 1'b0) begin bad++; $display("FAIL dc_err got=%b exp=0", rate_err); end
  endtask

  task automatic test_extremes();
    int got, prev; logic [3:0] vp;
    prev = 32767;
    for (int w = 0; w < 50; w++) begin
      for (int i = 0; i < DECIM; i++) feed(-32768);
      close_win(1'b0, 0, got, vp);
      total++; if (got !== exp_dat) begin bad++; $display("FAIL neg_dat w=%0d got=%0d exp=%0d", w, got, exp_dat); end
      total++; if (got > prev) begin bad++; $display("FAIL neg_wrap w=%0d got=%0d exp<=%0d", w, got, prev); end
      prev = got;
    end
    total++; if (got !== -32768) begin bad++; $display("FAIL neg_final got=%0d exp=-32768", got); end
    for (int w = 0; w < 50; w++) begin
      for (int i = 0; i < DECIM; i++) feed(32767);
      close_win(1'b0, 0, got, vp);
      total++; if (got !== exp_dat) begin bad++; $display("FAIL pos_dat w=%0d got=%0d exp=%0d", w, got, exp_dat); end
      total++; if (got < prev) begin bad++; $display("FAIL pos_wrap w=%0d got=%0d exp>=%0d", w, got, prev); end
      prev = got;
    end
`ifdef FM_AUDIO_DEEMPH_EN
    total++; if (got != 32767 && got != 32766) begin bad++; $display("FAIL pos_final got=%0d exp=32766..32767", got); end
`else
    total++; if (got !== 32767) begin bad++; $display("FAIL pos_final got=%0d exp=32767", got); end
`endif
    total++; if (rate_err !== 1'b0) begin bad++; $display("FAIL ext_err got=%b exp=0", rate_err); end
  endtask

  task automatic test_coincident();
    int got; logic [3:0] vp;
    for (int i = 0; i < DECIM; i++) feed(0);
    close_win(1'b1, 4000, got, vp);
    total++; if (got !== exp_dat) begin bad++; $display("FAIL coin_close got=%0d exp=%0d", got, exp_dat); end
    for (int i = 0; i < DECIM - 1; i++) feed(0);
    close_win(1'b0, 0, got, vp);
    total++; if (got !== exp_dat) begin bad++; $display("FAIL coin_next got=%0d exp=%0d", got, exp_dat); end
`ifndef FM_AUDIO_DEEMPH_EN
    total++; if (got !== 500) begin bad++; $display("FAIL coin_x got=%0d exp=500", got); end
`endif
    total++; if (rate_err !== 1'b0) begin bad++; $display("FAIL coin_err got=%b exp=0", rate_err); end
  endtask

  task automatic test_short_window();
    int got; logic [3:0] vp;
    for (int i = 0; i < DECIM - 1; i++) feed(800);
    close_win(1'b0, 0, got, vp);
    total++; if (got !== exp_dat) begin bad++; $display("FAIL short_dat got=%0d exp=%0d", got, exp_dat); end
`ifndef FM_AUDIO_DEEMPH_EN
    total++; if (got !== 700) begin bad++; $display("FAIL short_x got=%0d exp=700", got); end
`endif
    total++; if (vp !== 4'b0100) begin bad++; $display("FAIL short_vld got=%b exp=0100", vp); end
    total++; if (rate_err !== 1'b1) begin bad++; $display("FAIL short_err got=%b exp=1", rate_err); end
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < DECIM; i++) feed(800);
      close_win(1'b0, 0, got, vp);
      total++; if (rate_err !== 1'b1) begin bad++; $display("FAIL sticky_err w=%0d got=%b exp=1", w, rate_err); end
    end
  endtask

  task automatic test_random();
    int got; logic [3:0] vp; bit pend, coinc; int n, cv;
    pend = 1'b0;
    for (int w = 0; w < 30; w++) begin
      n = pend ? DECIM - 1 : DECIM;
      for (int i = 0; i < n; i++) feed(int'($urandom_range(0, 65535)) - 32768);
      coinc = ($urandom_range(0, 3) == 0);
      cv = int'($urandom_range(0, 65535)) - 32768;
      close_win(coinc, cv, got, vp);
      pend = coinc;
      total++; if (got !== exp_dat) begin bad++; $display("FAIL rnd_dat w=%0d got=%0d exp=%0d", w, got, exp_dat); end
      total++; if (vp !== 4'b0100) begin bad++; $display("FAIL rnd_vld w=%0d got=%b exp=0100", w, vp); end
      total++; if (rate_err !== m_err) begin bad++; $display("FAIL rnd_err w=%0d got=%b exp=%b", w, rate_err, m_err); end
    end
    if (pend) begin
      for (int i = 0; i < DECIM - 1; i++) feed(0);
      close_win(1'b0, 0, got, vp);
    end
  endtask

  task automatic test_reset_mid();
    int got; logic [3:0] vp; bit saw;
    for (int i = 0; i < DECIM; i++) feed(1000);
    close_win(1'b0, 0, got, vp);
    for (int i = 0; i < DECIM; i++) feed(2000);
    en32k = 1'b1;
    @(posedge clk); #1;
    en32k = 1'b0;
    reset = 1'b1;
    #1;
    total++; if (audio_dat !== 16'd0) begin bad++; $display("FAIL rmid_dat got=%0d exp=0", audio_dat); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_vld got=%b exp=0", out_valid); end
    total++; if (rate_err !== 1'b0) begin bad++; $display("FAIL rmid_err got=%b exp=0", rate_err); end
    saw = 1'b0;
    for (int i = 0; i < 2; i++) begin @(negedge clk); if (out_valid !== 1'b0) saw = 1'b1; end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (out_valid !== 1'b0) saw = 1'b1; end
    total++; if (saw) begin bad++; $display("FAIL rmid_pulse got=1 exp=0"); end
    for (int i = 0; i < DECIM; i++) feed(1200);
    close_win(1'b0, 0, got, vp);
    total++; if (got !== exp_dat) begin bad++; $display("FAIL rpost_dat got=%0d exp=%0d", got, exp_dat); end
`ifdef FM_AUDIO_DEEMPH_EN
    total++; if (got !== 600) begin bad++; $display("FAIL rpost_abs got=%0d exp=600", got); end
`else
    total++; if (got !== 1200) begin bad++; $display("FAIL rpost_abs got=%0d exp=1200", got); end
`endif
    total++; if (vp !== 4'b0100) begin bad++; $display("FAIL rpost_vld got=%b exp=0100", vp); end
    total++; if (rate_err !== 1'b0) begin bad++; $display("FAIL rpost_err got=%b exp=0", rate_err); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_dc();
    test_extremes();
    test_coincident();
    test_short_window();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
